// File: rtl/dff_pipe_elastic_pkg.sv
// Shared constants and helpers for the elastic register pipeline cell.
package dff_pipe_elastic_pkg;

  localparam int DFF_PIPE_MAX_DEPTH = 16;

  // Occupancy counter width: must be able to represent 0..depth inclusive.
  function automatic int dff_pipe_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One slot of the elastic pipeline: a valid bit plus a data register that
// only loads on valid source data, so bubbles never toggle the datapath.
module dff_pipe_stage #(
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [Width-1:0] DRST,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_src_vld,
  input  logic [Width-1:0] i_src_dat,
  output logic             o_vld,
  output logic [Width-1:0] o_dat
);

  logic             r_vld;
  logic [Width-1:0] r_dat;

  // NOTE: non-blocking assignments make every stage sample its neighbour's
  // pre-edge value, so the chain shifts by exactly one slot per clock.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_vld <= 1'b0;
      r_dat <= DRST;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld <= i_src_vld;
      if (i_src_vld) r_dat <= i_src_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/dff_pipe_elastic.sv
// Depth-stage elastic register pipeline with bubble compression, synchronous
// flush and a registered occupancy count.
module dff_pipe_elastic
  import dff_pipe_elastic_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 2,
  parameter int CntW  = dff_pipe_cnt_w(Depth)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [Width-1:0] DRST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [Width-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [Width-1:0] OUT_DATA,
  output logic [CntW-1:0]  OCC
);

  if (Depth < 1 || Depth > DFF_PIPE_MAX_DEPTH) begin : g_depth_check
    $error("dff_pipe_elastic: Depth %0d outside 1..%0d", Depth, DFF_PIPE_MAX_DEPTH);
  end

  logic [Depth:0]                w_rdy;
  logic [Depth-1:0]              w_vld;
  logic [Depth-1:0][Width-1:0]   w_dat;
  logic                          w_in_hs;
  logic                          w_out_hs;
  logic [CntW-1:0]               r_occ;

  // NOTE: every bit of w_rdy is written on every evaluation, so no latch.
  // A stage is ready when empty or when the stage ahead of it will move.
  always_comb begin
    w_rdy[Depth] = OUT_READY;
    for (int i = Depth - 1; i >= 0; i--) begin
      w_rdy[i] = ~w_vld[i] | w_rdy[i+1];
    end
  end

  for (genvar i = 0; i < Depth; i++) begin : g_stage
    logic             w_src_vld;
    logic [Width-1:0] w_src_dat;

    if (i == 0) begin : g_head
      assign w_src_vld = IN_VALID;
      assign w_src_dat = IN_DATA;
    end else begin : g_body
      assign w_src_vld = w_vld[i-1];
      assign w_src_dat = w_dat[i-1];
    end

    dff_pipe_stage #(.Width(Width)) u_stage (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .DRST      (DRST),
      .i_flush   (FLUSH),
      .i_load    (w_rdy[i]),
      .i_src_vld (w_src_vld),
      .i_src_dat (w_src_dat),
      .o_vld     (w_vld[i]),
      .o_dat     (w_dat[i])
    );
  end

  assign IN_READY  = w_rdy[0] & ~FLUSH;
  assign OUT_VALID = w_vld[Depth-1];
  assign OUT_DATA  = w_dat[Depth-1];
  assign w_in_hs   = IN_VALID & IN_READY;
  assign w_out_hs  = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_occ <= '0;
    end else if (FLUSH) begin
      r_occ <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_occ <= r_occ + CntW'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_occ <= r_occ - CntW'(1);
    end
  end

  assign OCC = r_occ;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RSTN) begin
      assert (!$isunknown(w_vld) && !$isunknown(r_occ))
        else $error("dff_pipe_elastic: unknown value on valid bits or occupancy");
      assert (!(IN_VALID && IN_READY && $isunknown(IN_DATA)))
        else $error("dff_pipe_elastic: unknown IN_DATA on accepted input");
    end
  end
`endif

endmodule

// File: doc/dff_pipe_elastic.md
Name: dff_pipe_elastic

Overview:
- Parametrised successor to the single enabled reset-value flop: a chain of Depth enabled register stages with a per-stage valid bit and valid/ready flow control.
- Stages compress bubbles. Each stage has a reset value. A synchronous flush clears the pipeline, and an occupancy count is exported.
- Used as the standard retiming/pipelining primitive on NoC datapaths where back-pressure must cross the registered boundary.

Parameters:
- Width, 8, data bits per stage.
- Depth, 2, number of register stages; legal range 1..16.
- CntW, $clog2(Depth+1), width of occupancy count (derived, not overridden).

Ports:
- CLK  in  1  clock, all state on posedge.
- RSTN  in  1  asynchronous active-low reset.
- DRST  in  Width  data value loaded into every stage on reset.
- FLUSH  in  1  synchronous clear of all valid bits.
- IN_VALID  in  1  upstream data valid.
- IN_READY  out  1  block accepts IN_DATA this cycle.
- IN_DATA  in  Width  upstream data.
- OUT_VALID  out  1  last stage holds valid data.
- OUT_READY  in  1  downstream accepts OUT_DATA.
- OUT_DATA  out  Width  last-stage data.
- OCC  out  CntW  number of valid stages.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - all valid bits 0; all stage data = DRST; OCC=0.
  - OUT_VALID=0 and OUT_DATA=DRST.
  - IN_READY=1 once FLUSH=0.
- Stage i (0 = input side, Depth-1 = output side) holds vld[i] and dat[i].
- Per-stage ready: rdy[i] = ~vld[i] | rdy[i+1], with rdy[Depth] = OUT_READY. This is a combinational chain, so bubbles collapse.
- IN_READY = rdy[0] & ~FLUSH.
- Stage i loads when rdy[i]=1:
  - vld[i] <= src valid; dat[i] <= src data, but only if the source valid is 1. Data is held otherwise, so no toggling on bubbles.
  - Source is stage i-1, or IN_VALID/IN_DATA for i=0.
- Stage with rdy[i]=0 holds vld and dat (stall).
- OUT_VALID = vld[Depth-1]; OUT_DATA = dat[Depth-1].
- Latency: Depth cycles from accepted input to OUT_VALID when never stalled.
- Throughput: 1 item per cycle sustained while OUT_READY=1.
- Capacity: Depth items. When full and OUT_READY=0, IN_READY=0. When full and OUT_READY=1, accept and emit in the same cycle.
- FLUSH=1:
  - next cycle all vld=0; data registers untouched.
  - IN_READY=0 that cycle, so no input is accepted.
  - OUT_VALID still reflects current state that cycle. A handshake completing in the flush cycle counts as delivered.
- OCC: registered count of valid stages.
  - +1 on input handshake, -1 on output handshake, unchanged when both occur or neither.
  - Forced to 0 by FLUSH.
  - Always equals popcount(vld); never exceeds Depth and never wraps.
- Ordering: strict FIFO order; no duplication or loss except by FLUSH/reset.
- Reset asserted mid-transfer: all in-flight items discarded immediately; outputs go to reset values asynchronously.
- Simulation-only check (excluded under SYNTHESIS): after reset release, no vld bit and no OCC bit is X. Also checked: IN_VALID with IN_READY=1 accompanied by X on IN_DATA.

Decomposition:
- Shared package: no typedefs required. The CntW derivation function and the Depth legal-range constant (DFF_PIPE_MAX_DEPTH=16) go in the common cell package. An elaboration-time check rejects Depth outside 1..16.
- Sub-module: dff_pipe_stage (one vld/dat slot with load/hold logic, DRST reset value, async RSTN). It is instantiated Depth times in a generate loop, with the ready chain in the parent.

Test Plan:
- Reset: Depth=3, DRST=8'hA5, RSTN low -> OUT_DATA=8'hA5, OUT_VALID=0, OCC=0, IN_READY=1.
- Streaming: Depth=3, OUT_READY=1, send 8'h01..8'h08 back-to-back -> OUT_DATA=8'h01 valid 3 cycles after first accept, then one item per cycle in order, OCC steady at 3.
- Back-pressure fill: OUT_READY=0, IN_VALID=1 continuously, Depth=3 -> exactly 3 accepts, IN_READY=0 thereafter, OCC=3. Release OUT_READY -> 8'h01,8'h02,8'h03 in order with no loss.
- Bubble collapse: send one item, wait, hold OUT_READY=0 for 5 cycles, then send two more -> items pack forward, OCC=3, IN_READY falls only when all 3 stages are valid.
- Flush: OCC=2 with IN_VALID=1 and FLUSH=1 -> IN_READY=0 that cycle; next cycle OUT_VALID=0, OCC=0; subsequent input accepted normally.
- Async reset mid-stream: RSTN low while OCC=2 -> OUT_VALID=0, OUT_DATA=DRST, OCC=0 without a clock edge; resumes cleanly after release.
